// File: rtl/pulse_pacer.sv
// pulse_pacer
//   Feeds a fast-to-slow toggle pulse synchronizer from the clk_fast side. Raw single-cycle
//   event requests are counted in a pending counter and re-emitted as single-cycle pulses.
//   Each pulse starts at least GAP cycles after the previous one, so the slow domain sees
//   every pulse as a separate toggle. Events that arrive while the counter is full are lost
//   and recorded in a sticky overflow flag.
//
// Parameters
//   GAP    min clk_fast cycles between successive pulse_out rising edges (>= 2)
//   CNT_W  pending counter width; up to 2^CNT_W-1 events can be queued
//
// Ports
//   clk_fast   in   1      clock, all logic on the rising edge
//   rst_n      in   1      asynchronous active-low reset
//   event_in   in   1      one event request per cycle sampled high
//   clr_ovf    in   1      synchronous clear of ovf (a new overflow wins)
//   pulse_out  out  1      paced single-cycle pulse, taken straight from the state register
//   pending    out  CNT_W  events queued but not yet emitted
//   busy       out  1      high while a pulse or gap window is active or events are queued
//   ovf        out  1      sticky: at least one event was dropped

module pulse_pacer #(
   parameter int unsigned GAP   = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk_fast,
   input  logic             rst_n,
   input  logic             event_in,
   input  logic             clr_ovf,
   output logic             pulse_out,
   output logic [CNT_W-1:0] pending,
   output logic             busy,
   output logic             ovf
);

   // The gap counter only has to hold GAP-2; keep it at least one bit wide for GAP=2.
   localparam int unsigned     GapW    = (GAP > 2) ? $clog2(GAP - 1) : 1;
   localparam logic [GapW-1:0] GapLoad = GapW'(GAP - 2);

   typedef enum logic [1:0] {
      StIdle,
      StFire,
      StGap
   } state_e;

   state_e           state_q, state_d;
   logic [GapW-1:0]  gap_q, gap_d;
   logic [CNT_W-1:0] pending_q, pending_d;
   logic             ovf_q, ovf_d;

   logic pend_nz;
   logic cnt_full;
   logic inc;
   logic dec;
   logic ovf_set;

   assign pend_nz  = (pending_q != '0);
   assign cnt_full = (pending_q == {CNT_W{1'b1}});

   // Pacing FSM. FIRE lasts one cycle, then GAP holds for GAP-1 cycles (load GAP-2 and
   // count down to zero inclusive), so consecutive FIRE cycles are exactly GAP apart.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      unique case (state_q)
         StIdle: begin
            if (pend_nz) begin
               state_d = StFire;
            end
         end
         StFire: begin
            state_d = StGap;
            gap_d   = GapLoad;
         end
         StGap: begin
            if (gap_q != '0) begin
               gap_d = gap_q - 1'b1;
            end else if (pend_nz) begin
               state_d = StFire;
            end else begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            gap_d   = '0;
         end
      endcase
   end

   // Pending counter. An event is consumed on the edge that enters FIRE; since FIRE is only
   // entered with pending != 0 the counter cannot underflow. A full counter still accepts an
   // event when one is consumed in the same cycle.
   assign inc = event_in;
   assign dec = (state_d == StFire);

   always_comb begin
      pending_d = pending_q;
      ovf_set   = 1'b0;
      if (inc && !dec) begin
         if (cnt_full) begin
            ovf_set = 1'b1;
         end else begin
            pending_d = pending_q + 1'b1;
         end
      end else if (!inc && dec) begin
         pending_d = pending_q - 1'b1;
      end
   end

   // A drop in the same cycle as clr_ovf keeps the flag set.
   always_comb begin
      ovf_d = ovf_q;
      if (ovf_set) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         gap_q     <= '0;
         pending_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gap_q     <= gap_d;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
      end
   end

   assign pulse_out = (state_q == StFire);
   assign pending   = pending_q;
   assign busy      = (state_q != StIdle) || pend_nz;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pulse_pacer.sv
module tb_pulse_pacer;

   logic       clk_fast = 1'b0;
   logic       rst_n    = 1'b0;

   // Main instance: GAP=8, CNT_W=4
   logic       event_in = 1'b0;
   logic       clr_ovf  = 1'b0;
   logic       pulse_out;
   logic [3:0] pending;
   logic       busy;
   logic       ovf;

   // Second instance: GAP=2, CNT_W=4
   logic       event2 = 1'b0;
   logic       pulse2;
   logic [3:0] pending2;
   logic       busy2;
   logic       ovf2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_fast = ~clk_fast;

   pulse_pacer #(
      .GAP   (8),
      .CNT_W (4)
   ) dut (
      .clk_fast  (clk_fast),
      .rst_n     (rst_n),
      .event_in  (event_in),
      .clr_ovf   (clr_ovf),
      .pulse_out (pulse_out),
      .pending   (pending),
      .busy      (busy),
      .ovf       (ovf)
   );

   pulse_pacer #(
      .GAP   (2),
      .CNT_W (4)
   ) dut2 (
      .clk_fast  (clk_fast),
      .rst_n     (rst_n),
      .event_in  (event2),
      .clr_ovf   (1'b0),
      .pulse_out (pulse2),
      .pending   (pending2),
      .busy      (busy2),
      .ovf       (ovf2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance over one rising edge and settle so outputs can be sampled.
   task automatic tick();
      @(posedge clk_fast);
      #1;
   endtask

   // Leaves the bench mid-cycle with reset released; the next rising edge is edge 0.
   task automatic do_reset();
      event_in = 1'b0;
      event2   = 1'b0;
      clr_ovf  = 1'b0;
      rst_n    = 1'b0;
      repeat (2) @(posedge clk_fast);
      @(negedge clk_fast);
      rst_n = 1'b1;
   endtask

   function automatic logic [3:0] t2_pending(input int e);
      if (e <= 1) return 4'd1;
      if (e <= 8) return 4'd2;
      if (e <= 16) return 4'd1;
      return 4'd0;
   endfunction

   initial begin
      int   pulses;
      logic prev;

      // T1: reset state, single event, 2-cycle latency, busy through the gap window
      do_reset();
      chk("t1_rst_pulse", pulse_out, 1'b0);
      chk("t1_rst_pending", pending, 4'd0);
      chk("t1_rst_busy", busy, 1'b0);
      chk("t1_rst_ovf", ovf, 1'b0);
      event_in = 1'b1;
      tick();                                    // edge 0
      event_in = 1'b0;
      chk("t1_e0_pending", pending, 4'd1);
      chk("t1_e0_pulse", pulse_out, 1'b0);
      chk("t1_e0_busy", busy, 1'b1);
      tick();                                    // edge 1
      chk("t1_e1_pulse", pulse_out, 1'b1);
      chk("t1_e1_pending", pending, 4'd0);
      for (int e = 2; e <= 8; e++) begin
         tick();
         chk("t1_gap_pulse", pulse_out, 1'b0);
         chk("t1_gap_busy", busy, 1'b1);
      end
      tick();                                    // edge 9
      chk("t1_e9_busy", busy, 1'b0);
      chk("t1_e9_pulse", pulse_out, 1'b0);

      // T2: three back-to-back events -> pulses at edges 1, 9, 17
      do_reset();
      pulses = 0;
      for (int e = 0; e <= 30; e++) begin
         event_in = (e <= 2);
         tick();
         chk("t2_pulse", pulse_out, (e == 1 || e == 9 || e == 17));
         chk("t2_pending", pending, t2_pending(e));
         if (pulse_out) pulses++;
      end
      event_in = 1'b0;
      chk("t2_count", pulses, 3);
      chk("t2_ovf", ovf, 1'b0);
      chk("t2_busy", busy, 1'b0);

      // T3 + T4: 20 events saturate the counter; edges 18,19 dropped; clr_ovf collides with
      // the drop at edge 19 (flag stays), then clears alone at edge 20
      do_reset();
      pulses = 0;
      for (int e = 0; e <= 150; e++) begin
         event_in = (e <= 19);
         clr_ovf  = (e == 19 || e == 20);
         tick();
         chk("t3_pulse", pulse_out, (e >= 1 && e <= 137 && ((e - 1) % 8) == 0));
         if (pulse_out) pulses++;
         if (e == 16) chk("t3_pending_full", pending, 4'd15);
         if (e == 17) chk("t3_ovf_e17", ovf, 1'b0);
         if (e == 17) chk("t3_pending_e17", pending, 4'd15);
         if (e == 18) chk("t3_ovf_e18", ovf, 1'b1);
         if (e == 19) chk("t4_ovf_clr_vs_set", ovf, 1'b1);
         if (e == 20) chk("t4_ovf_clr", ovf, 1'b0);
      end
      event_in = 1'b0;
      clr_ovf  = 1'b0;
      chk("t3_count", pulses, 18);
      chk("t3_pending_end", pending, 4'd0);
      chk("t3_busy_end", busy, 1'b0);

      // T5: asynchronous reset mid-burst discards the queue
      do_reset();
      for (int e = 0; e <= 5; e++) begin
         event_in = 1'b1;
         tick();
      end
      event_in = 1'b0;
      chk("t5_pre_pending", pending, 4'd5);
      chk("t5_pre_busy", busy, 1'b1);
      chk("t5_pre_pulse", pulse_out, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_async_pending", pending, 4'd0);
      chk("t5_async_busy", busy, 1'b0);
      chk("t5_async_pulse", pulse_out, 1'b0);
      @(negedge clk_fast);
      rst_n = 1'b1;
      pulses = 0;
      for (int e = 0; e < 30; e++) begin
         tick();
         if (pulse_out) pulses++;
      end
      chk("t5_no_pulses", pulses, 0);
      chk("t5_busy", busy, 1'b0);

      // T6: GAP=2 with event held high for 10 cycles -> pulses on every other edge
      do_reset();
      prev   = 1'b0;
      pulses = 0;
      for (int e = 0; e <= 24; e++) begin
         event2 = (e <= 9);
         tick();
         chk("t6_pulse", pulse2, ((e % 2) == 1 && e <= 19));
         chk("t6_adjacent", prev & pulse2, 1'b0);
         if (pulse2) pulses++;
         prev = pulse2;
      end
      event2 = 1'b0;
      chk("t6_count", pulses, 10);
      chk("t6_pending", pending2, 4'd0);
      chk("t6_ovf", ovf2, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
